// File: rtl/rs_encoder_15_11.sv
// rs_encoder_15_11: systematic serial RS(15,11) encoder over GF(16), field poly x^4+x+1.
// Optional macro RS_ENC_ERR_INJ_EN adds ERR_MASK, XORed into each symbol as it loads the output register.
module rs_encoder_15_11 #(
    parameter int M = 4,
    parameter int N = 15,
    parameter int K = 11
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         IN_VALID,
    input  logic [M-1:0] IN_SERIAL,
    output logic         IN_READY,
`ifdef RS_ENC_ERR_INJ_EN
    input  logic [M-1:0] ERR_MASK,
`endif
    output logic         OUT_VALID,
    output logic [M-1:0] OUT_SERIAL,
    output logic         OUT_LAST,
    input  logic         OUT_READY
);

    localparam logic [0:0] ST_MSG = 1'b0;
    localparam logic [0:0] ST_PAR = 1'b1;

    localparam logic [3:0] MSG_LAST = 4'(K - 1);
    localparam logic [3:0] PAR_LAST = 4'(N - K - 1);

    // Generator g(x) = x^4 + 13x^3 + 12x^2 + 8x + 7
    localparam logic [3:0] G3 = 4'd13;
    localparam logic [3:0] G2 = 4'd12;
    localparam logic [3:0] G1 = 4'd8;
    localparam logic [3:0] G0 = 4'd7;

    logic [0:0]   state;
    logic [3:0]   cnt;
    logic [M-1:0] r0, r1, r2, r3;
    logic [M-1:0] fb;
    logic [M-1:0] mask;
    logic         free;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            // multiply by alpha, reducing x^4 -> x + 1
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
        end
        return acc;
    endfunction

`ifdef RS_ENC_ERR_INJ_EN
    assign mask = ERR_MASK;
`else
    assign mask = '0;
`endif

    // IN_READY is forced low while RESET is asserted, not just after the first reset edge.
    always_comb begin
        free     = !OUT_VALID || OUT_READY;
        IN_READY = RESET && (state == ST_MSG) && free;
        fb       = IN_SERIAL ^ r3;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= ST_MSG;
            cnt        <= '0;
            r0         <= '0;
            r1         <= '0;
            r2         <= '0;
            r3         <= '0;
            OUT_VALID  <= 1'b0;
            OUT_SERIAL <= '0;
            OUT_LAST   <= 1'b0;
        end else if (free) begin
            case (state)
                ST_MSG: begin
                    if (IN_VALID) begin
                        r3         <= r2 ^ gf_mul(G3, fb);
                        r2         <= r1 ^ gf_mul(G2, fb);
                        r1         <= r0 ^ gf_mul(G1, fb);
                        r0         <= gf_mul(G0, fb);
                        OUT_SERIAL <= IN_SERIAL ^ mask;
                        OUT_VALID  <= 1'b1;
                        OUT_LAST   <= 1'b0;
                        if (cnt == MSG_LAST) begin
                            state <= ST_PAR;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        OUT_VALID <= 1'b0;
                        OUT_LAST  <= 1'b0;
                    end
                end
                ST_PAR: begin
                    OUT_SERIAL <= r3 ^ mask;
                    r3         <= r2;
                    r2         <= r1;
                    r1         <= r0;
                    r0         <= '0;
                    OUT_VALID  <= 1'b1;
                    OUT_LAST   <= (cnt == PAR_LAST);
                    if (cnt == PAR_LAST) begin
                        state <= ST_MSG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_MSG;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Directed bench for rs_encoder_15_11: hand-computed parity, GF(16) syndrome check, stalls and reset.
module tb_rs_encoder_15_11;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [3:0] IN_SERIAL = '0;
    logic       IN_READY;
    logic       OUT_VALID;
    logic [3:0] OUT_SERIAL;
    logic       OUT_LAST;
    logic       OUT_READY = 1'b1;
`ifdef RS_ENC_ERR_INJ_EN
    logic [3:0] ERR_MASK = '0;
    int         inj_at = -1;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] msg[11];
    logic [3:0] exp_cw[15];
    logic [3:0] cw[15];
    logic       lst[15];
    int         ocnt;

    logic [3:0] gexp[15];
    int         glog[16];

    always #5 CLK = ~CLK;

    rs_encoder_15_11 #(.M(4), .N(15), .K(11)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IN_VALID(IN_VALID),
        .IN_SERIAL(IN_SERIAL),
        .IN_READY(IN_READY),
`ifdef RS_ENC_ERR_INJ_EN
        .ERR_MASK(ERR_MASK),
`endif
        .OUT_VALID(OUT_VALID),
        .OUT_SERIAL(OUT_SERIAL),
        .OUT_LAST(OUT_LAST),
        .OUT_READY(OUT_READY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tb_mul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Feeds msg[] back-to-back, collects 15 output symbols; optionally stalls OUT_READY after stall_at symbols.
    task automatic run_word(input int stall_at);
        int idx;
        int cyc;
        bit acc;
        idx  = 0;
        cyc  = 0;
        ocnt = 0;
        while (ocnt < 15 && cyc < 60) begin
            IN_VALID  = (idx < 11);
            IN_SERIAL = (idx < 11) ? msg[idx] : 4'h0;
`ifdef RS_ENC_ERR_INJ_EN
            ERR_MASK = (idx == inj_at) ? 4'h5 : 4'h0;
`endif
            #1;
            acc = IN_VALID && IN_READY;
            @(posedge CLK);
            #1;
            cyc++;
            if (acc) idx++;
            if (OUT_VALID) begin
                cw[ocnt]  = OUT_SERIAL;
                lst[ocnt] = OUT_LAST;
                ocnt++;
                if (ocnt == 15) chk("b2b_in_ready", 32'(IN_READY), 32'd1);
                if (ocnt == stall_at) begin
                    OUT_READY = 1'b0;
                    repeat (3) begin
                        @(posedge CLK);
                        #1;
                        chk("stall_valid", 32'(OUT_VALID), 32'd1);
                        chk("stall_data", 32'(OUT_SERIAL), 32'(exp_cw[ocnt-1]));
                        chk("stall_last", 32'(OUT_LAST), 32'(ocnt == 15));
                        chk("stall_in_ready", 32'(IN_READY), 32'd0);
                    end
                    OUT_READY = 1'b1;
                end
            end
        end
        IN_VALID = 1'b0;
`ifdef RS_ENC_ERR_INJ_EN
        ERR_MASK = 4'h0;
`endif
        chk("word_len", 32'(ocnt), 32'd15);
    endtask

    task automatic cmp_word(input string tag);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("%s_sym%0d", tag, i), 32'(cw[i]), 32'(exp_cw[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(lst[i]), 32'(i == 14));
        end
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] s;

        v = 4'h1;
        for (int k = 0; k < 15; k++) begin
            gexp[k] = v;
            glog[v] = k;
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
        end

        // Reset held for two clocks
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_last", 32'(OUT_LAST), 32'd0);
        chk("rst_out_serial", 32'(OUT_SERIAL), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd0);

        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_in_ready", 32'(IN_READY), 32'd1);
        chk("post_rst_out_valid", 32'(OUT_VALID), 32'd0);

        // All-zero message
        for (int i = 0; i < 11; i++) msg[i] = 4'h0;
        for (int i = 0; i < 15; i++) exp_cw[i] = 4'h0;
        run_word(0);
        cmp_word("zero");

        // Ten zeros then 1: parity equals g(x) low coefficients
        msg[10] = 4'h1;
        exp_cw[10] = 4'h1;
        exp_cw[11] = 4'd13;
        exp_cw[12] = 4'd12;
        exp_cw[13] = 4'd8;
        exp_cw[14] = 4'd7;
        run_word(0);
        cmp_word("unit");

        // Same word with a 3-cycle output stall showing p2
        run_word(13);
        cmp_word("stall");

        // Message 1..11: passthrough and zero syndromes at alpha^1..alpha^4
        for (int i = 0; i < 11; i++) msg[i] = 4'(i + 1);
        run_word(0);
        for (int i = 0; i < 11; i++) chk($sformatf("seq_msg%0d", i), 32'(cw[i]), 32'(i + 1));
        chk("seq_last", 32'(lst[14]), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            s = 4'h0;
            for (int i = 0; i < 15; i++) s = s ^ tb_mul(cw[i], gexp[(j * (14 - i)) % 15]);
            chk($sformatf("seq_syn%0d", j), 32'(s), 32'd0);
        end

        // Reset after 5 message symbols, then a clean all-zero word
        msg[0] = 4'h9; msg[1] = 4'h3; msg[2] = 4'hE; msg[3] = 4'h6; msg[4] = 4'h2;
        for (int i = 0; i < 5; i++) begin
            IN_VALID  = 1'b1;
            IN_SERIAL = msg[i];
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        RESET    = 1'b0;
        @(posedge CLK);
        #1;
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_out_serial", 32'(OUT_SERIAL), 32'd0);
        chk("midrst_out_last", 32'(OUT_LAST), 32'd0);
        chk("midrst_in_ready", 32'(IN_READY), 32'd0);
        RESET = 1'b1;
        for (int i = 0; i < 11; i++) msg[i] = 4'h0;
        for (int i = 0; i < 15; i++) exp_cw[i] = 4'h0;
        run_word(0);
        cmp_word("postrst");

`ifdef RS_ENC_ERR_INJ_EN
        // Error mask on the 3rd symbol only
        msg[10] = 4'h1;
        exp_cw[2]  = 4'h5;
        exp_cw[10] = 4'h1;
        exp_cw[11] = 4'd13;
        exp_cw[12] = 4'd12;
        exp_cw[13] = 4'd8;
        exp_cw[14] = 4'd7;
        inj_at = 2;
        run_word(0);
        inj_at = -1;
        cmp_word("inj");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
